pkt_ff_wptr_ctrl: RTL and testbench

Write-side pointer controller for the asynchronous packet FIFO, operating in the write clock domain. Tracks a speculative write pointer for the packet in flight and a committed pointer, published in Gray code to the read domain, that advances only on a clean EOP, so the reader never sees partial packets. Detects FIFO full against the synchronised read pointer. Drops packets that error or overflow by rewinding to the last committed location.

---
 rtl/pkt_ff_pkg.sv | 29 ++
 rtl/pkt_ff_full_chk.sv | 22 ++
 rtl/pkt_ff_wptr_ctrl.sv | 147 ++++++++++++++
 tb/tb_pkt_ff_wptr_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_ff_pkg.sv
// Shared types and helpers for the asynchronous packet FIFO.
// Gray/binary conversions work on MAX_W-bit operands: a narrower pointer is
// zero-extended on the way in and cast back to its own width on the way out.
// The result is exact for any width up to MAX_W, because the zero upper bits
// contribute nothing to either conversion.
package pkt_ff_pkg;

    localparam int MAX_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PKT  = 2'd1,
        DROP = 2'd2
    } state_t;

    function automatic logic [MAX_W-1:0] bin2gry(input logic [MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [MAX_W-1:0] gry2bin(input logic [MAX_W-1:0] gry);
        logic [MAX_W-1:0] bin;
        bin[MAX_W-1] = gry[MAX_W-1];
        for (int i = MAX_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gry[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/pkt_ff_full_chk.sv
// Full detector: converts the synchronised Gray read pointer to binary and
// flags when ptr_bin is exactly one FIFO depth ahead of it.
// The wrap bits differ and the address bits match.
module pkt_ff_full_chk
    import pkt_ff_pkg::*;
#(
    parameter int PTR_W = 8
) (
    input  logic [PTR_W:0] ptr_bin,
    input  logic [PTR_W:0] rptr_gry_sync,
    output logic           full
);

    localparam int AW = PTR_W + 1;

    logic [PTR_W:0] rd_bin;

    assign rd_bin = AW'(gry2bin(MAX_W'(rptr_gry_sync)));
    assign full   = (ptr_bin[PTR_W] != rd_bin[PTR_W]) &&
                    (ptr_bin[PTR_W-1:0] == rd_bin[PTR_W-1:0]);

endmodule

// File: rtl/pkt_ff_wptr_ctrl.sv
// Write-side pointer controller for the asynchronous packet FIFO.
// wr_bin is the speculative pointer of the packet in flight. cmt_bin is the
// committed pointer, which is published to the read side as Gray and advances
// only on a clean EOP. A packet that errors, overflows, or loses its EOP is
// dropped by rewinding wr_bin to cmt_bin.
// Optional feature macro: PKT_FF_WPTR_DROP_CNT_EN. When it is defined, the
// saturating drop_cnt register is built. When it is undefined, drop_cnt is
// tied to zero.
module pkt_ff_wptr_ctrl
    import pkt_ff_pkg::*;
#(
    parameter int PTR_W      = 8,
    parameter int DROP_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid,
    input  logic                  sop,
    input  logic                  eop,
    input  logic                  error,
    input  logic [PTR_W:0]        rptr_gry_sync,
    output logic                  wen,
    output logic [PTR_W-1:0]      waddr,
    output logic [PTR_W:0]        wptr_gry,
    output logic                  full,
    output logic                  pkt_drop,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    localparam int AW = PTR_W + 1;

    logic [PTR_W:0] wr_bin, cmt_bin;
    logic [PTR_W:0] wr_nxt, cmt_nxt;
    state_t         state, state_nxt;
    logic           full_cmt;
    logic [1:0]     drops;

    // full is reported for the speculative pointer. A sop beat restarts from
    // cmt_bin, so that beat is checked for space at cmt_bin instead.
    pkt_ff_full_chk #(.PTR_W(PTR_W)) u_full_wr (
        .ptr_bin       (wr_bin),
        .rptr_gry_sync (rptr_gry_sync),
        .full          (full)
    );

    pkt_ff_full_chk #(.PTR_W(PTR_W)) u_full_cmt (
        .ptr_bin       (cmt_bin),
        .rptr_gry_sync (rptr_gry_sync),
        .full          (full_cmt)
    );

    // Beat acceptance, RAM write strobe, pointer and FSM next-state.
    // At most two drops can occur in one cycle: an abandoned partial packet
    // and a failing sop beat that restarts in the same cycle.
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        wen       = 1'b0;
        waddr     = wr_bin[PTR_W-1:0];
        wr_nxt    = wr_bin;
        cmt_nxt   = cmt_bin;
        state_nxt = state;
        drops     = 2'd0;
        if (valid && sop) begin
            // A new packet always starts from the committed pointer.
            // If the current packet has no EOP yet, it is abandoned.
            if (state == PKT) begin
                drops = drops + 2'd1;
            end
            waddr = cmt_bin[PTR_W-1:0];
            if (!error && !full_cmt) begin
                wen    = 1'b1;
                wr_nxt = cmt_bin + AW'(1);
                if (eop) begin
                    cmt_nxt   = cmt_bin + AW'(1);
                    state_nxt = IDLE;
                end else begin
                    state_nxt = PKT;
                end
            end else begin
                drops     = drops + 2'd1;
                wr_nxt    = cmt_bin;
                state_nxt = eop ? IDLE : DROP;
            end
        end else if (valid) begin
            case (state)
                IDLE: ;  // a beat arriving outside a packet is ignored
                PKT: begin
                    if (!error && !full) begin
                        wen    = 1'b1;
                        wr_nxt = wr_bin + AW'(1);
                        if (eop) begin
                            cmt_nxt   = wr_bin + AW'(1);
                            state_nxt = IDLE;
                        end
                    end else begin
                        drops     = 2'd1;
                        wr_nxt    = cmt_bin;
                        state_nxt = eop ? IDLE : DROP;
                    end
                end
                DROP: begin
                    if (eop) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Pointer, FSM and status registers.
    // wptr_gry is loaded from cmt_nxt, so it appears one cycle after the EOP beat.
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_bin   <= '0;
            cmt_bin  <= '0;
            state    <= IDLE;
            wptr_gry <= '0;
            pkt_drop <= 1'b0;
        end else begin
            wr_bin   <= wr_nxt;
            cmt_bin  <= cmt_nxt;
            state    <= state_nxt;
            wptr_gry <= AW'(bin2gry(MAX_W'(cmt_nxt)));
            pkt_drop <= (drops != 2'd0);
        end
    end

`ifdef PKT_FF_WPTR_DROP_CNT_EN
    logic [DROP_CNT_W:0] cnt_sum;

    assign cnt_sum = {1'b0, drop_cnt} + (DROP_CNT_W + 1)'(drops);

    // Saturating drop counter: a carry out of the top bit pins it at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= '0;
        end else begin
            drop_cnt <= cnt_sum[DROP_CNT_W] ? '1 : cnt_sum[DROP_CNT_W-1:0];
        end
    end
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_pkt_ff_wptr_ctrl.sv
// Directed testbench for pkt_ff_wptr_ctrl with PTR_W=4 (depth 16) and
// DROP_CNT_W=2. Inputs change on the falling edge. Outputs are sampled 1
// time unit later, so combinational outputs show the current beat and
// registered outputs show the previous rising edge.
// Expected drop_cnt follows PKT_FF_WPTR_DROP_CNT_EN.
module tb_pkt_ff_wptr_ctrl;

    localparam int PTR_W      = 4;
    localparam int DROP_CNT_W = 2;

    logic                  clk   = 1'b0;
    logic                  rst   = 1'b1;
    logic                  valid = 1'b0;
    logic                  sop   = 1'b0;
    logic                  eop   = 1'b0;
    logic                  error = 1'b0;
    logic [PTR_W:0]        rptr_gry_sync = '0;
    logic                  wen;
    logic [PTR_W-1:0]      waddr;
    logic [PTR_W:0]        wptr_gry;
    logic                  full;
    logic                  pkt_drop;
    logic [DROP_CNT_W-1:0] drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pkt_ff_wptr_ctrl #(.PTR_W(PTR_W), .DROP_CNT_W(DROP_CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .valid         (valid),
        .sop           (sop),
        .eop           (eop),
        .error         (error),
        .rptr_gry_sync (rptr_gry_sync),
        .wen           (wen),
        .waddr         (waddr),
        .wptr_gry      (wptr_gry),
        .full          (full),
        .pkt_drop      (pkt_drop),
        .drop_cnt      (drop_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic beat(input logic v, input logic s, input logic e, input logic er);
        @(negedge clk);
        valid = v;
        sop   = s;
        eop   = e;
        error = er;
        #1;
    endtask

    task automatic idle();
        beat(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Expected drop counter after n dropped packets (2-bit, saturating).
    function automatic logic [31:0] exp_cnt(input int n);
`ifdef PKT_FF_WPTR_DROP_CNT_EN
        return (n > 3) ? 32'd3 : 32'(n);
`else
        return (n > 0) ? 32'd0 : 32'd0;
`endif
    endfunction

    task automatic send_pkt(input string tag, input int len, input int start);
        for (int i = 0; i < len; i++) begin
            beat(1'b1, (i == 0), (i == len - 1), 1'b0);
            check({tag, "_wen"}, 32'(wen), 32'd1);
            check({tag, "_waddr"}, 32'(waddr), 32'((start + i) % 16));
        end
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_wen", 32'(wen), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_wptr", 32'(wptr_gry), 32'd0);
        check("rst_drop", 32'(pkt_drop), 32'd0);
        check("rst_cnt", 32'(drop_cnt), 32'd0);
        rst = 1'b0;

        // 3-beat clean packet: addresses 0..2, commit to 3 (Gray 0x02)
        send_pkt("p3", 3, 0);
        check("p3_pre_commit", 32'(wptr_gry), 32'h00);
        idle();
        check("p3_wptr", 32'(wptr_gry), 32'h02);
        check("p3_nodrop", 32'(pkt_drop), 32'd0);

        // 4-beat packet with error on beat 3
        beat(1, 1, 0, 0);
        check("err_b1_addr", 32'(waddr), 32'd3);
        beat(1, 0, 0, 0);
        check("err_b2_addr", 32'(waddr), 32'd4);
        beat(1, 0, 0, 1);
        check("err_b3_wen", 32'(wen), 32'd0);
        beat(1, 0, 1, 0);
        check("err_b4_wen", 32'(wen), 32'd0);
        check("err_drop", 32'(pkt_drop), 32'd1);
        idle();
        check("err_drop_clr", 32'(pkt_drop), 32'd0);
        check("err_wptr", 32'(wptr_gry), 32'h02);
        check("err_cnt", 32'(drop_cnt), exp_cnt(1));
        send_pkt("after_err", 1, 3);
        idle();
        check("after_err_wptr", 32'(wptr_gry), 32'h06);

        // Missing EOP: second sop restarts from the commit address 4
        beat(1, 1, 0, 0);
        check("meop_b1_addr", 32'(waddr), 32'd4);
        beat(1, 0, 0, 0);
        check("meop_b2_addr", 32'(waddr), 32'd5);
        beat(1, 1, 0, 0);
        check("meop_sop_wen", 32'(wen), 32'd1);
        check("meop_sop_addr", 32'(waddr), 32'd4);
        beat(1, 0, 1, 0);
        check("meop_eop_addr", 32'(waddr), 32'd5);
        check("meop_drop", 32'(pkt_drop), 32'd1);
        idle();
        check("meop_wptr", 32'(wptr_gry), 32'h05);
        check("meop_drop_clr", 32'(pkt_drop), 32'd0);
        check("meop_cnt", 32'(drop_cnt), exp_cnt(2));

        // Overflow: reader at 6 (Gray 0x05), 16 beats fit, 17th hits full
        rptr_gry_sync = 5'h05;
        idle();
        check("ovf_full0", 32'(full), 32'd0);
        for (int i = 0; i < 16; i++) begin
            beat(1'b1, (i == 0), 1'b0, 1'b0);
            check("ovf_wen", 32'(wen), 32'd1);
            check("ovf_full", 32'(full), 32'd0);
            check("ovf_addr", 32'(waddr), 32'((6 + i) % 16));
        end
        beat(1, 0, 0, 0);
        check("ovf17_full", 32'(full), 32'd1);
        check("ovf17_wen", 32'(wen), 32'd0);
        idle();
        check("ovf_drop", 32'(pkt_drop), 32'd1);
        check("ovf_rewind_full", 32'(full), 32'd0);
        check("ovf_wptr", 32'(wptr_gry), 32'h05);
        send_pkt("post_ovf", 2, 6);
        idle();
        check("post_ovf_wptr", 32'(wptr_gry), 32'h0C);
        check("post_ovf_cnt", 32'(drop_cnt), exp_cnt(3));

        // Commit pointer wrap 8 -> 16 -> 24 -> 0 with the reader keeping up
        rptr_gry_sync = 5'h0C;
        send_pkt("w1", 8, 8);
        idle();
        check("w1_wptr", 32'(wptr_gry), 32'h18);
        rptr_gry_sync = 5'h18;
        send_pkt("w2", 8, 0);
        idle();
        check("w2_wptr", 32'(wptr_gry), 32'h14);
        rptr_gry_sync = 5'h14;
        send_pkt("w3", 8, 8);
        idle();
        check("w3_wptr", 32'(wptr_gry), 32'h00);
        check("w3_full", 32'(full), 32'd0);
        rptr_gry_sync = 5'h18;  // reader at 16, writer at 0
        idle();
        check("wrap_full1", 32'(full), 32'd1);
        rptr_gry_sync = 5'h19;  // reader at 17
        idle();
        check("wrap_full0", 32'(full), 32'd0);
        send_pkt("w4", 1, 0);
        idle();
        check("w4_wptr", 32'(wptr_gry), 32'h01);
        check("w4_full", 32'(full), 32'd1);
        rptr_gry_sync = 5'h01;  // reader at 1
        idle();
        check("w4_full_clr", 32'(full), 32'd0);

        // Two more dropped packets: counter saturates when enabled
        beat(1, 1, 1, 1);
        check("sat_b1_wen", 32'(wen), 32'd0);
        beat(1, 1, 1, 1);
        check("sat_b2_wen", 32'(wen), 32'd0);
        check("sat_drop1", 32'(pkt_drop), 32'd1);
        idle();
        check("sat_drop2", 32'(pkt_drop), 32'd1);
        check("sat_cnt4", 32'(drop_cnt), exp_cnt(4));
        idle();
        check("sat_drop_clr", 32'(pkt_drop), 32'd0);
        check("sat_cnt5", 32'(drop_cnt), exp_cnt(5));
        check("sat_wptr", 32'(wptr_gry), 32'h01);

        // Reset in the middle of a packet: nothing commits
        beat(1, 1, 0, 0);
        check("mrst_b1_addr", 32'(waddr), 32'd1);
        beat(1, 0, 0, 0);
        check("mrst_b2_addr", 32'(waddr), 32'd2);
        valid = 1'b0;
        sop   = 1'b0;
        rptr_gry_sync = '0;
        rst   = 1'b1;
        #1;
        check("mrst_wptr", 32'(wptr_gry), 32'd0);
        check("mrst_cnt", 32'(drop_cnt), 32'd0);
        check("mrst_full", 32'(full), 32'd0);
        check("mrst_wen", 32'(wen), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        send_pkt("post_rst", 1, 0);
        idle();
        check("post_rst_wptr", 32'(wptr_gry), 32'h01);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
